bfly_out_scaler: RTL and testbench



---
 rtl/bfly_pkg.sv | 59 +++++
 rtl/bfly_out_scaler_if.sv | 31 +++
 rtl/bfly_pair_fifo.sv | 59 +++++
 rtl/bfly_out_scaler.sv | 159 +++++++++++++++
 tb/tb_bfly_out_scaler.sv | 256 +++++++++++++++++++++++++
 5 files changed

// File: rtl/bfly_pkg.sv
// Shared types and the round/saturate helper for the butterfly output scaler.
// Turns full-precision butterfly results back into OUT_W-bit samples.
package bfly_pkg;

  localparam int BFLY_DATA_W = 27;
  localparam int BFLY_TWID_W = 16;
  localparam int BFLY_W      = BFLY_DATA_W + BFLY_TWID_W + 1;
  localparam int BFLY_LAT    = 5;
  localparam int BFLY_SHIFT  = 15;
  localparam int OUT_W       = 27;
  localparam int PAIR_DEPTH  = 8;

  typedef logic signed [OUT_W-1:0] sample_t;

  typedef struct packed {
    sample_t p_r;
    sample_t p_i;
    sample_t q_r;
    sample_t q_i;
  } bfly_pair_t;

  typedef struct packed {
    sample_t value;
    logic    sat;
  } round_sat_t;

  typedef enum logic {
    S_P = 1'b0,
    S_Q = 1'b1
  } ser_state_t;

  // Adds half an LSB and shifts arithmetically, so ties round toward +inf.
  // A 64-bit intermediate leaves headroom above the widest butterfly result.
  function automatic round_sat_t round_sat(input logic signed [63:0] value,
                                           input int shift,
                                           input int out_width);
    logic signed [63:0] biased;
    logic signed [63:0] shifted;
    logic signed [63:0] max_v;
    logic signed [63:0] min_v;
    round_sat_t         res;
    biased  = value + (64'sd1 <<< (shift - 1));
    shifted = biased >>> shift;
    max_v   = (64'sd1 <<< (out_width - 1)) - 64'sd1;
    min_v   = -(64'sd1 <<< (out_width - 1));
    if (shifted > max_v) begin
      res.value = max_v[OUT_W-1:0];
      res.sat   = 1'b1;
    end else if (shifted < min_v) begin
      res.value = min_v[OUT_W-1:0];
      res.sat   = 1'b1;
    end else begin
      res.value = shifted[OUT_W-1:0];
      res.sat   = 1'b0;
    end
    return res;
  endfunction

endpackage

// File: rtl/bfly_out_scaler_if.sv
// Bundle of launch credit, butterfly results and the serialized output stream.
// The slave side is the scaler; the master side is the environment around it.
interface bfly_out_scaler_if;
  import bfly_pkg::*;

  logic                     issue_valid;
  logic                     issue_ready;
  logic signed [BFLY_W-1:0] yp_r;
  logic signed [BFLY_W-1:0] yp_i;
  logic signed [BFLY_W-1:0] yq_r;
  logic signed [BFLY_W-1:0] yq_i;
  logic                     out_valid;
  logic                     out_ready;
  sample_t                  out_r;
  sample_t                  out_i;
  logic                     out_is_q;
  logic                     sat_flag;
  logic                     sat_clr;
  logic                     ovf_err;

  modport master (
    output issue_valid, yp_r, yp_i, yq_r, yq_i, out_ready, sat_clr,
    input  issue_ready, out_valid, out_r, out_i, out_is_q, sat_flag, ovf_err
  );

  modport slave (
    input  issue_valid, yp_r, yp_i, yq_r, yq_i, out_ready, sat_clr,
    output issue_ready, out_valid, out_r, out_i, out_is_q, sat_flag, ovf_err
  );

endinterface

// File: rtl/bfly_pair_fifo.sv
// Synchronous FIFO of rounded result pairs with an occupancy count.
// Pushes while full are dropped; the caller flags them.
module bfly_pair_fifo
  import bfly_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   push,
  input  bfly_pair_t             push_data,
  input  logic                   pop,
  output bfly_pair_t             head,
  output logic [$clog2(DEPTH):0] count,
  output logic                   full
);

  localparam int AW = $clog2(DEPTH);

  bfly_pair_t    mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;

  assign full    = (count == (AW + 1)'(DEPTH));
  assign do_push = push & ~full;
  assign do_pop  = pop & (count != '0);
  assign head    = mem[rd_ptr];

  // Storage carries data only, so it is left out of reset.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= push_data;
    end
  end

  // Power-of-two depth lets the pointers wrap naturally.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/bfly_out_scaler.sv
// Rounds/saturates butterfly yp/yq results, queues them and serializes yp then yq.
// Launch credits cover both queued pairs and pairs still inside the butterfly.
module bfly_out_scaler #(
  parameter int DATA_WIDTH = bfly_pkg::BFLY_DATA_W,
  parameter int TWID_WIDTH = bfly_pkg::BFLY_TWID_W,
  parameter int SHIFT      = bfly_pkg::BFLY_SHIFT,
  parameter int OUT_WIDTH  = bfly_pkg::OUT_W,
  parameter int BFLY_LAT   = bfly_pkg::BFLY_LAT,
  parameter int DEPTH      = bfly_pkg::PAIR_DEPTH
) (
  input logic               clk,
  input logic               rst_n,
  bfly_out_scaler_if.slave  bus
);
  import bfly_pkg::*;

  localparam int IN_W  = DATA_WIDTH + TWID_WIDTH + 1;
  localparam int CNT_W = $clog2(DEPTH) + 1;
  localparam int SUM_W = $clog2(DEPTH + BFLY_LAT + 1) + 1;

  logic signed [IN_W-1:0] yp_r;
  logic signed [IN_W-1:0] yp_i;
  logic signed [IN_W-1:0] yq_r;
  logic signed [IN_W-1:0] yq_i;
  logic [BFLY_LAT-1:0]    vld_dly;
  logic                   launch;
  logic                   push;
  logic                   pop;
  logic                   has_data;
  logic                   fifo_full;
  logic [CNT_W-1:0]       fifo_count;
  logic [SUM_W-1:0]       inflight;
  logic [SUM_W-1:0]       credit_used;
  round_sat_t             rs_pr;
  round_sat_t             rs_pi;
  round_sat_t             rs_qr;
  round_sat_t             rs_qi;
  logic                   push_sat;
  bfly_pair_t             push_data;
  bfly_pair_t             head;
  ser_state_t             state;
  ser_state_t             state_nxt;
  logic                   sat_flag_q;
  logic                   ovf_err_q;

  assign yp_r = bus.yp_r;
  assign yp_i = bus.yp_i;
  assign yq_r = bus.yq_r;
  assign yq_i = bus.yq_i;

  // ---- launch tracking: one bit per butterfly cycle ----
  assign launch = bus.issue_valid & bus.issue_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_dly <= '0;
    end else begin
      vld_dly <= {vld_dly[BFLY_LAT-2:0], launch};
    end
  end

  // The tap goes high while the matching butterfly result is stable.
  assign push = vld_dly[BFLY_LAT-1];

  always_comb begin
    inflight = '0;
    for (int i = 0; i < BFLY_LAT; i++) begin
      inflight = inflight + SUM_W'(vld_dly[i]);
    end
  end

  assign credit_used     = SUM_W'(fifo_count) + inflight;
  assign bus.issue_ready = rst_n & (credit_used < SUM_W'(DEPTH));

  // ---- round and saturate the four components at the push point ----
  always_comb begin
    rs_pr         = round_sat(64'(yp_r), SHIFT, OUT_WIDTH);
    rs_pi         = round_sat(64'(yp_i), SHIFT, OUT_WIDTH);
    rs_qr         = round_sat(64'(yq_r), SHIFT, OUT_WIDTH);
    rs_qi         = round_sat(64'(yq_i), SHIFT, OUT_WIDTH);
    push_data.p_r = rs_pr.value;
    push_data.p_i = rs_pi.value;
    push_data.q_r = rs_qr.value;
    push_data.q_i = rs_qi.value;
    push_sat      = rs_pr.sat | rs_pi.sat | rs_qr.sat | rs_qi.sat;
  end

  // ---- pair queue ----
  bfly_pair_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (push),
    .push_data (push_data),
    .pop       (pop),
    .head      (head),
    .count     (fifo_count),
    .full      (fifo_full)
  );

  // A new saturation outranks a same-cycle clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sat_flag_q <= 1'b0;
      ovf_err_q  <= 1'b0;
    end else begin
      if (push && push_sat) begin
        sat_flag_q <= 1'b1;
      end else if (bus.sat_clr) begin
        sat_flag_q <= 1'b0;
      end
      if (push && fifo_full) begin
        ovf_err_q <= 1'b1;
      end
    end
  end

  assign bus.sat_flag = sat_flag_q;
  assign bus.ovf_err  = ovf_err_q;

  // ---- serializer: p sample, then q sample, then pop ----
  assign has_data = (fifo_count != '0);
  assign pop      = has_data & bus.out_ready & (state == S_Q);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_P;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    if (has_data && bus.out_ready) begin
      state_nxt = (state == S_P) ? S_Q : S_P;
    end
  end

  always_comb begin
    bus.out_valid = 1'b0;
    bus.out_is_q  = 1'b0;
    bus.out_r     = '0;
    bus.out_i     = '0;
    if (has_data) begin
      bus.out_valid = 1'b1;
      if (state == S_Q) begin
        bus.out_is_q = 1'b1;
        bus.out_r    = head.q_r;
        bus.out_i    = head.q_i;
      end else begin
        bus.out_r    = head.p_r;
        bus.out_i    = head.p_i;
      end
    end
  end

endmodule

// File: tb/tb_bfly_out_scaler.sv
// Directed bench for bfly_out_scaler with a behavioural butterfly and an output scoreboard.
module tb_bfly_out_scaler;
  import bfly_pkg::*;

  typedef struct {
    longint r;
    longint i;
    bit     q;
  } exp_t;

  logic   clk = 1'b0;
  logic   rst_n;
  int     checks = 0;
  int     errors = 0;
  int     nl = 0;
  int     nsamp = 0;
  int     bf_n = 0;
  int     bf_pipe [5] = '{default: 0};
  longint lv_pr [1024] = '{default: 0};
  longint lv_pi [1024] = '{default: 0};
  longint lv_qr [1024] = '{default: 0};
  longint lv_qi [1024] = '{default: 0};
  exp_t   sbq [$];

  bfly_out_scaler_if bus ();

  bfly_out_scaler dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Butterfly stand-in: result for a launch is presented four edges after it.
  always @(posedge clk) begin
    if (bus.issue_valid && bus.issue_ready) bf_n <= bf_n + 1;
    bf_pipe[0] <= bf_n;
    for (int i = 4; i > 0; i--) bf_pipe[i] <= bf_pipe[i-1];
  end

  always_comb begin
    bus.yp_r = lv_pr[bf_pipe[4]][BFLY_W-1:0];
    bus.yp_i = lv_pi[bf_pipe[4]][BFLY_W-1:0];
    bus.yq_r = lv_qr[bf_pipe[4]][BFLY_W-1:0];
    bus.yq_i = lv_qi[bf_pipe[4]][BFLY_W-1:0];
  end

  function automatic longint rnd(input longint x);
    longint y;
    y = (x + 64'sd16384) >>> 15;
    if (y > 64'sd67108863) y = 64'sd67108863;
    if (y < -64'sd67108864) y = -64'sd67108864;
    return y;
  endfunction

  task automatic chk(input string tag, input logic signed [63:0] obs, input logic signed [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic set_lv(input int idx, input longint pr, input longint pi, input longint qr, input longint qi);
    lv_pr[idx] = pr;
    lv_pi[idx] = pi;
    lv_qr[idx] = qr;
    lv_qi[idx] = qi;
  endtask

  function automatic longint rand_val(input int k);
    if ((k % 16) == 7) return longint'($signed($urandom())) * 2048;
    return longint'($signed($urandom())) * 64;
  endfunction

  // Called at a negedge after inputs are set; scores the coming edge, returns at the next negedge.
  task automatic tick();
    exp_t e;
    #1;
    if (bus.issue_valid && bus.issue_ready) begin
      sbq.push_back('{r: rnd(lv_pr[nl]), i: rnd(lv_pi[nl]), q: 1'b0});
      sbq.push_back('{r: rnd(lv_qr[nl]), i: rnd(lv_qi[nl]), q: 1'b1});
      nl++;
    end
    if (bus.out_valid && bus.out_ready) begin
      nsamp++;
      if (sbq.size() == 0) begin
        chk("sb_extra_sample", bus.out_valid, 0);
      end else begin
        e = sbq.pop_front();
        chk("sb_out_r", bus.out_r, e.r);
        chk("sb_out_i", bus.out_i, e.i);
        chk("sb_out_is_q", bus.out_is_q, e.q);
      end
    end
    @(negedge clk);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n0;
    int ns0;
    int cyc;
    bit seen;

    rst_n           = 1'b0;
    bus.issue_valid = 1'b0;
    bus.out_ready   = 1'b0;
    bus.sat_clr     = 1'b0;
    repeat (3) @(negedge clk);

    // reset state
    chk("rst_out_valid", bus.out_valid, 0);
    chk("rst_out_r", bus.out_r, 0);
    chk("rst_out_i", bus.out_i, 0);
    chk("rst_out_is_q", bus.out_is_q, 0);
    chk("rst_sat_flag", bus.sat_flag, 0);
    chk("rst_ovf_err", bus.ovf_err, 0);
    chk("rst_issue_ready", bus.issue_ready, 0);
    rst_n = 1'b1;
    #1;
    chk("post_rst_issue_ready", bus.issue_ready, 1);
    @(negedge clk);

    // rounding and latency
    set_lv(nl, 64'sd114688, -64'sd114688, 64'sd98304, 64'sd0);
    bus.out_ready   = 1'b1;
    bus.issue_valid = 1'b1;
    tick();
    bus.issue_valid = 1'b0;
    repeat (4) tick();
    chk("lat_t4_no_valid", bus.out_valid, 0);
    tick();
    chk("lat_t5_valid", bus.out_valid, 1);
    chk("lat_t5_is_q", bus.out_is_q, 0);
    chk("round_p_r", bus.out_r, 4);
    chk("round_p_i", bus.out_i, -3);
    tick();
    chk("lat_t6_valid", bus.out_valid, 1);
    chk("lat_t6_is_q", bus.out_is_q, 1);
    chk("round_q_r", bus.out_r, 3);
    chk("round_q_i", bus.out_i, 0);
    tick();
    chk("lat_t7_no_valid", bus.out_valid, 0);
    chk("round_no_sat", bus.sat_flag, 0);

    // saturation and sticky flag clear
    set_lv(nl, 64'sd2199023255552, 64'sd0, 64'sd0, -64'sd4398046511104);
    bus.issue_valid = 1'b1;
    tick();
    bus.issue_valid = 1'b0;
    repeat (5) tick();
    chk("sat_p_r", bus.out_r, 67108863);
    chk("sat_p_i", bus.out_i, 0);
    chk("sat_flag_set", bus.sat_flag, 1);
    tick();
    chk("sat_q_is_q", bus.out_is_q, 1);
    chk("sat_q_i", bus.out_i, -67108864);
    tick();
    chk("sat_flag_sticky", bus.sat_flag, 1);
    bus.sat_clr = 1'b1;
    tick();
    bus.sat_clr = 1'b0;
    chk("sat_flag_cleared", bus.sat_flag, 0);

    // backpressure and credit
    bus.out_ready   = 1'b0;
    bus.issue_valid = 1'b1;
    n0 = nl;
    for (int k = 0; k < 16; k++) begin
      set_lv(nl, (longint'(nl) * 3 + 1) * 32768, -longint'(nl) * 32768 - 16384,
             longint'(nl) * 1000, -longint'(nl) * 7777);
      tick();
    end
    chk("bp_launch_count", nl - n0, 8);
    chk("bp_issue_ready_low", bus.issue_ready, 0);
    chk("bp_ovf_err", bus.ovf_err, 0);
    chk("bp_out_valid", bus.out_valid, 1);
    chk("bp_head_is_p", bus.out_is_q, 0);
    bus.issue_valid = 1'b0;
    bus.out_ready   = 1'b1;
    ns0 = nsamp;
    tick();
    chk("bp_ready_after_p", bus.issue_ready, 0);
    chk("bp_then_q", bus.out_is_q, 1);
    tick();
    chk("bp_ready_after_pop", bus.issue_ready, 1);
    repeat (16) tick();
    chk("bp_drained_samples", nsamp - ns0, 16);
    chk("bp_empty", bus.out_valid, 0);
    chk("bp_ovf_err_end", bus.ovf_err, 0);

    // random stall against the scoreboard
    n0  = nl;
    cyc = 0;
    bus.issue_valid = 1'b1;
    while ((nl - n0) < 200 && cyc < 4000) begin
      bus.out_ready = 1'($urandom_range(0, 1));
      set_lv(nl, rand_val(nl), rand_val(nl + 1), rand_val(nl + 2), rand_val(nl + 3));
      tick();
      cyc++;
    end
    bus.issue_valid = 1'b0;
    chk("rand_launches", nl - n0, 200);
    cyc = 0;
    while (sbq.size() != 0 && cyc < 2000) begin
      bus.out_ready = 1'($urandom_range(0, 1));
      tick();
      cyc++;
    end
    chk("rand_scoreboard_empty", sbq.size(), 0);
    chk("rand_ovf_err", bus.ovf_err, 0);

    // reset with work queued and in flight
    bus.out_ready   = 1'b0;
    bus.issue_valid = 1'b1;
    repeat (5) begin
      set_lv(nl, longint'(nl) * 65536, 64'sd32768, -64'sd65536, longint'(nl));
      tick();
    end
    bus.issue_valid = 1'b0;
    repeat (2) tick();
    chk("mid_out_valid", bus.out_valid, 1);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_out_valid", bus.out_valid, 0);
    chk("mid_rst_out_r", bus.out_r, 0);
    chk("mid_rst_out_i", bus.out_i, 0);
    chk("mid_rst_out_is_q", bus.out_is_q, 0);
    chk("mid_rst_issue_ready", bus.issue_ready, 0);
    chk("mid_rst_sat_flag", bus.sat_flag, 0);
    chk("mid_rst_ovf_err", bus.ovf_err, 0);
    sbq.delete();
    @(negedge clk);
    @(negedge clk);
    rst_n         = 1'b1;
    bus.out_ready = 1'b1;
    seen = 1'b0;
    repeat (10) begin
      if (bus.out_valid) seen = 1'b1;
      tick();
    end
    chk("post_rst_no_stale_valid", seen, 0);
    chk("post_rst_issue_ready_high", bus.issue_ready, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
